// File: rtl/round_pack.sv
// Final FPU stage: rounds a normalised mantissa/exponent pair and packs it into an
// IEEE-754 single-precision word through a two-stage valid/ready pipeline.
module round_pack #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      sign_in,
    input  logic [FRAC_W+4:0]         mantisa_norm,
    input  logic [EXP_W-1:0]          exp_norm,
    input  logic [1:0]                rmode,
    input  logic [1:0]                special_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXP_W+FRAC_W:0]     result,
    output logic                      flag_overflow,
    output logic                      flag_underflow,
    output logic                      flag_inexact
);

    localparam int MW = FRAC_W + 5;
    localparam logic [EXP_W:0] EXP_ONE = 1;
    localparam logic [EXP_W:0] EXP_MAX = (1 << EXP_W) - 1;

    typedef enum logic [1:0] {
        RM_RNE  = 2'b00,
        RM_RTZ  = 2'b01,
        RM_PINF = 2'b10,
        RM_NINF = 2'b11
    } rmode_t;

    typedef enum logic [1:0] {
        SP_NORMAL = 2'b00,
        SP_INF    = 2'b01,
        SP_NAN    = 2'b10,
        SP_ZERO   = 2'b11
    } special_t;

    logic s2_adv;
    logic s1_adv;
    logic s1_valid;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    // Stage 1 combinational rounding
    logic [MW-2:0]       m_sh;
    logic [EXP_W:0]      exp_adj;
    logic                bit_g, bit_r, bit_s, bit_l;
    logic                rnd_inexact;
    logic                rnd_inc;
    logic                frac_carry;
    logic [FRAC_W-1:0]   rnd_frac;
    logic                rnd_carry;
    logic                in_zero;
    logic                in_unf;

    always_comb begin
        m_sh    = mantisa_norm[MW-2:0];
        exp_adj = {1'b0, exp_norm};
        if (mantisa_norm[MW-1]) begin
            m_sh    = {mantisa_norm[MW-1:2], mantisa_norm[1] | mantisa_norm[0]};
            exp_adj = exp_adj + EXP_ONE;
        end
        bit_g       = m_sh[2];
        bit_r       = m_sh[1];
        bit_s       = m_sh[0];
        bit_l       = m_sh[3];
        rnd_inexact = bit_g | bit_r | bit_s;
        case (rmode_t'(rmode))
            RM_RNE:  rnd_inc = bit_g & (bit_r | bit_s | bit_l);
            RM_RTZ:  rnd_inc = 1'b0;
            RM_PINF: rnd_inc = rnd_inexact & !sign_in;
            default: rnd_inc = rnd_inexact & sign_in;
        endcase
        // Fraction sum carries into the hidden bit; a mantissa overflow needs that bit set too.
        {frac_carry, rnd_frac} = {1'b0, m_sh[MW-3:3]} + {{FRAC_W{1'b0}}, rnd_inc};
        rnd_carry = frac_carry & m_sh[MW-2];
        in_zero   = (mantisa_norm == '0);
        in_unf    = (exp_norm == '0) && !in_zero;
    end

    logic                s1_sign;
    logic [FRAC_W-1:0]   s1_frac;
    logic                s1_carry;
    logic [EXP_W:0]      s1_exp;
    logic [1:0]          s1_rmode;
    logic [1:0]          s1_special;
    logic                s1_inexact;
    logic                s1_zero;
    logic                s1_unf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_sign    <= 1'b0;
            s1_frac    <= '0;
            s1_carry   <= 1'b0;
            s1_exp     <= '0;
            s1_rmode   <= 2'b00;
            s1_special <= 2'b00;
            s1_inexact <= 1'b0;
            s1_zero    <= 1'b0;
            s1_unf     <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign    <= sign_in;
                s1_frac    <= rnd_frac;
                s1_carry   <= rnd_carry;
                s1_exp     <= exp_adj;
                s1_rmode   <= rmode;
                s1_special <= special_in;
                s1_inexact <= rnd_inexact;
                s1_zero    <= in_zero;
                s1_unf     <= in_unf;
            end
        end
    end

    // Stage 2 combinational exponent adjust and packing
    logic [EXP_W:0]          exp_fin;
    logic [FRAC_W-1:0]       frac_fin;
    logic                    is_ovf;
    logic [EXP_W+FRAC_W:0]   inf_word;
    logic [EXP_W+FRAC_W:0]   max_word;
    logic [EXP_W+FRAC_W:0]   pack_result;
    logic                    pack_ovf;
    logic                    pack_unf;
    logic                    pack_inx;

    always_comb begin
        exp_fin  = s1_carry ? s1_exp + EXP_ONE : s1_exp;
        frac_fin = s1_carry ? '0 : s1_frac;
        is_ovf   = (exp_fin >= EXP_MAX);
        inf_word = {s1_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        max_word = {s1_sign, {(EXP_W-1){1'b1}}, 1'b0, {FRAC_W{1'b1}}};

        pack_result = {s1_sign, exp_fin[EXP_W-1:0], frac_fin};
        pack_ovf    = 1'b0;
        pack_unf    = 1'b0;
        pack_inx    = s1_inexact;

        if (special_t'(s1_special) != SP_NORMAL) begin
            pack_inx = 1'b0;
            case (special_t'(s1_special))
                SP_INF:  pack_result = inf_word;
                SP_NAN:  pack_result = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
                default: pack_result = {s1_sign, {(EXP_W+FRAC_W){1'b0}}};
            endcase
        end else if (s1_zero) begin
            pack_result = {s1_sign, {(EXP_W+FRAC_W){1'b0}}};
            pack_inx    = 1'b0;
        end else if (s1_unf) begin
            pack_result = {s1_sign, {(EXP_W+FRAC_W){1'b0}}};
            pack_unf    = 1'b1;
            pack_inx    = 1'b1;
        end else if (is_ovf) begin
            pack_ovf = 1'b1;
            pack_inx = 1'b1;
            // Directed modes saturate toward the direction they refuse to round past.
            case (rmode_t'(s1_rmode))
                RM_RNE:  pack_result = inf_word;
                RM_RTZ:  pack_result = max_word;
                RM_PINF: pack_result = s1_sign ? max_word : inf_word;
                default: pack_result = s1_sign ? inf_word : max_word;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid      <= 1'b0;
            result         <= '0;
            flag_overflow  <= 1'b0;
            flag_underflow <= 1'b0;
            flag_inexact   <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                result         <= pack_result;
                flag_overflow  <= pack_ovf;
                flag_underflow <= pack_unf;
                flag_inexact   <= pack_inx;
            end
        end
    end

endmodule

// File: tb/tb_round_pack.sv
// Scoreboard bench for round_pack: expected words are queued at input acceptance
// and compared in order as results leave the pipeline.
module tb_round_pack;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        sign_in;
    logic [27:0] mantisa_norm;
    logic [7:0]  exp_norm;
    logic [1:0]  rmode;
    logic [1:0]  special_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        flag_overflow;
    logic        flag_underflow;
    logic        flag_inexact;

    int compared;
    int failed;
    logic [34:0] exp_q[$];
    logic [34:0] mon_exp;

    localparam logic [1:0] RNE = 2'b00, RTZ = 2'b01, PINF = 2'b10, NINF = 2'b11;
    localparam logic [1:0] SP_NORM = 2'b00, SP_INF = 2'b01, SP_NAN = 2'b10, SP_ZERO = 2'b11;

    round_pack dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .sign_in        (sign_in),
        .mantisa_norm   (mantisa_norm),
        .exp_norm       (exp_norm),
        .rmode          (rmode),
        .special_in     (special_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .result         (result),
        .flag_overflow  (flag_overflow),
        .flag_underflow (flag_underflow),
        .flag_inexact   (flag_inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [34:0] ex(input logic [31:0] r, input logic o, input logic u, input logic x);
        return {o, u, x, r};
    endfunction

    // Output monitor: every accepted result must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            compared++;
            if (exp_q.size() == 0) begin
                failed++;
                $display("[TB] FAIL unexpected_output: got res=%h with empty scoreboard", result);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({flag_overflow, flag_underflow, flag_inexact, result} !== mon_exp) begin
                    failed++;
                    $display("[TB] FAIL scoreboard: got res=%h ovf=%b unf=%b inx=%b, want res=%h ovf=%b unf=%b inx=%b",
                             result, flag_overflow, flag_underflow, flag_inexact,
                             mon_exp[31:0], mon_exp[34], mon_exp[33], mon_exp[32]);
                end
            end
        end
    end

    task automatic send_beat(input logic s, input logic [27:0] m, input logic [7:0] e,
                             input logic [1:0] rm, input logic [1:0] sp, input logic [34:0] expv);
        logic acc;
        sign_in      = s;
        mantisa_norm = m;
        exp_norm     = e;
        rmode        = rm;
        special_in   = sp;
        in_valid     = 1'b1;
        acc          = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                exp_q.push_back(expv);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            compared++;
            failed++;
            $display("[TB] FAIL accept_timeout: in_ready=%b, want 1 within 50 cycles", in_ready);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        compared++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("[TB] FAIL drain_timeout: %0d results outstanding, want 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        compared++;
        if ({out_valid, flag_overflow, flag_underflow, flag_inexact} !== 4'b0 || result !== 32'h0) begin
            failed++;
            $display("[TB] FAIL reset_outputs: got ov=%b res=%h flags=%b%b%b, want all 0",
                     out_valid, result, flag_overflow, flag_underflow, flag_inexact);
        end
        compared++;
        if (in_ready !== 1'b1) begin
            failed++;
            $display("[TB] FAIL reset_in_ready: got %b, want 1", in_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_latency();
        out_ready = 1'b1;
        send_beat(1'b0, 28'h4000000, 8'd127, RNE, SP_NORM, ex(32'h3F800000, 0, 0, 0));
        @(negedge clk);
        compared++;
        if (out_valid !== 1'b0) begin
            failed++;
            $display("[TB] FAIL latency_early: out_valid=%b one cycle after accept, want 0", out_valid);
        end
        @(negedge clk);
        compared++;
        if (out_valid !== 1'b1) begin
            failed++;
            $display("[TB] FAIL latency_due: out_valid=%b two cycles after accept, want 1", out_valid);
        end
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic test_rounding();
        out_ready = 1'b1;
        send_beat(1'b0, 28'h4000004, 8'd127, RNE,  SP_NORM, ex(32'h3F800000, 0, 0, 1));
        send_beat(1'b0, 28'h400000C, 8'd127, RNE,  SP_NORM, ex(32'h3F800002, 0, 0, 1));
        send_beat(1'b0, 28'h4000006, 8'd127, RNE,  SP_NORM, ex(32'h3F800001, 0, 0, 1));
        send_beat(1'b0, 28'h7FFFFFC, 8'd127, RNE,  SP_NORM, ex(32'h40000000, 0, 0, 1));
        send_beat(1'b0, 28'h4000001, 8'd127, PINF, SP_NORM, ex(32'h3F800001, 0, 0, 1));
        send_beat(1'b1, 28'h4000001, 8'd127, PINF, SP_NORM, ex(32'hBF800000, 0, 0, 1));
        send_beat(1'b1, 28'h4000001, 8'd127, NINF, SP_NORM, ex(32'hBF800001, 0, 0, 1));
        send_beat(1'b0, 28'h400000F, 8'd127, RTZ,  SP_NORM, ex(32'h3F800001, 0, 0, 1));
        send_beat(1'b0, 28'h8000000, 8'd127, RNE,  SP_NORM, ex(32'h40000000, 0, 0, 0));
        send_beat(1'b0, 28'h8000008, 8'd127, RNE,  SP_NORM, ex(32'h40000000, 0, 0, 1));
        send_beat(1'b0, 28'h8000001, 8'd127, RNE,  SP_NORM, ex(32'h40000000, 0, 0, 1));
        drain();
    endtask

    task automatic test_overflow();
        out_ready = 1'b1;
        send_beat(1'b0, 28'h7FFFFFC, 8'd254, RNE,  SP_NORM, ex(32'h7F800000, 1, 0, 1));
        send_beat(1'b0, 28'h8000000, 8'd254, RTZ,  SP_NORM, ex(32'h7F7FFFFF, 1, 0, 1));
        send_beat(1'b1, 28'h8000000, 8'd254, PINF, SP_NORM, ex(32'hFF7FFFFF, 1, 0, 1));
        send_beat(1'b0, 28'h8000000, 8'd254, PINF, SP_NORM, ex(32'h7F800000, 1, 0, 1));
        send_beat(1'b1, 28'h8000000, 8'd254, NINF, SP_NORM, ex(32'hFF800000, 1, 0, 1));
        send_beat(1'b0, 28'h8000000, 8'd254, NINF, SP_NORM, ex(32'h7F7FFFFF, 1, 0, 1));
        send_beat(1'b0, 28'h7FFFFF8, 8'd254, RNE,  SP_NORM, ex(32'h7F7FFFFF, 0, 0, 0));
        drain();
    endtask

    task automatic test_specials();
        out_ready = 1'b1;
        send_beat(1'b0, 28'h4000004, 8'd127, RNE, SP_NAN,  ex(32'h7FC00000, 0, 0, 0));
        send_beat(1'b1, 28'h4000004, 8'd127, RNE, SP_INF,  ex(32'hFF800000, 0, 0, 0));
        send_beat(1'b1, 28'h4000000, 8'd127, RNE, SP_ZERO, ex(32'h80000000, 0, 0, 0));
        send_beat(1'b1, 28'h0000000, 8'd127, RNE, SP_NORM, ex(32'h80000000, 0, 0, 0));
        send_beat(1'b0, 28'h4000000, 8'd0,   RNE, SP_NORM, ex(32'h00000000, 0, 1, 1));
        send_beat(1'b0, 28'h8000000, 8'd254, RNE, SP_NAN,  ex(32'h7FC00000, 0, 0, 0));
        drain();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        send_beat(1'b0, 28'h4000000, 8'd127, RNE, SP_NORM, ex(32'h3F800000, 0, 0, 0));
        send_beat(1'b0, 28'h400000C, 8'd127, RNE, SP_NORM, ex(32'h3F800002, 0, 0, 1));
        @(negedge clk);
        compared++;
        if (in_ready !== 1'b0) begin
            failed++;
            $display("[TB] FAIL backpressure_in_ready: got %b with 2 beats held, want 0", in_ready);
        end
        fork
            begin
                send_beat(1'b0, 28'h7FFFFFC, 8'd127, RNE, SP_NORM, ex(32'h40000000, 0, 0, 1));
                send_beat(1'b1, 28'h4000000, 8'd128, RNE, SP_NORM, ex(32'hC0000000, 0, 0, 0));
            end
            begin
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    compared++;
                    if (out_valid !== 1'b1 || result !== 32'h3F800000) begin
                        failed++;
                        $display("[TB] FAIL stall_hold: got ov=%b res=%h, want ov=1 res=3f800000", out_valid, result);
                    end
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        send_beat(1'b0, 28'h4000000, 8'd127, RNE, SP_NORM, ex(32'h3F800000, 0, 0, 0));
        send_beat(1'b0, 28'h400000C, 8'd127, RNE, SP_NORM, ex(32'h3F800002, 0, 0, 1));
        rst = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        compared++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failed++;
            $display("[TB] FAIL reset_flush: got ov=%b ir=%b, want ov=0 ir=1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            compared++;
            if (out_valid !== 1'b0) begin
                failed++;
                $display("[TB] FAIL reset_phantom: got ov=%b after flush, want 0", out_valid);
            end
        end
        @(posedge clk);
        #1;
        send_beat(1'b0, 28'h4000006, 8'd127, RNE, SP_NORM, ex(32'h3F800001, 0, 0, 1));
        drain();
    endtask

    initial begin
        compared     = 0;
        failed       = 0;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        sign_in      = 1'b0;
        mantisa_norm = '0;
        exp_norm     = '0;
        rmode        = RNE;
        special_in   = SP_NORM;
        test_reset();
        test_latency();
        test_rounding();
        test_overflow();
        test_specials();
        test_back_to_back();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        failed++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
